reg_file_read_stage: RTL and testbench
======================================

Name: reg_file_read_stage

Overview:
- Operand-fetch stage directly downstream of register-field decode.
- Consumes a reg_file_read_params_t (rs1, rs2, rd) per instruction and owns the architectural register array.
- Reads both sources with writeback bypass and blocks RAW/WAW hazards through a busy-bit scoreboard.
- Presents registered operands to execute over a valid/ready handshake.

Parameters:
- XLEN, 32, register data width.
- NUM_REGS, 32, number of architectural registers; register address width is clog2(NUM_REGS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle
- in_params  in  reg_file_read_params_t  rs1/rs2/rd from decode
- in_writes_rd  in  1  instruction will write rd
- wb_valid  in  1  writeback strobe
- wb_rd  in  clog2(NUM_REGS)  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  squash the held output and the scoreboard
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_rs1_data  out  XLEN  rs1 operand
- out_rs2_data  out  XLEN  rs2 operand
- out_rd  out  clog2(NUM_REGS)  passed-through rd
- out_writes_rd  out  1  passed-through in_writes_rd

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values:
  - out_valid=0; out_rs1_data=0, out_rs2_data=0, out_rd=0, out_writes_rd=0.
  - All registers and all busy bits cleared.
- x0:
  - Always reads 0.
  - Writes to x0 are ignored.
  - busy[0] is never set.
- Writeback:
  - When wb_valid and wb_rd!=0, regs[wb_rd] <= wb_data at the clock edge.
  - In the same cycle, busy[wb_rd] is cleared.
- Bypass: a read of rsN!=0 while wb_valid and wb_rd==rsN returns wb_data, not the array value.
- Hazard is asserted when any of the following holds:
  - busy[rs1] set and not bypassed this cycle;
  - busy[rs2] set and not bypassed this cycle;
  - in_writes_rd, rd!=0, busy[rd] set and not cleared by this cycle's writeback (WAW).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready):
  - Output registers load the bypassed operands, rd and writes_rd; out_valid <= 1.
  - Latency is exactly 1 cycle.
  - If in_writes_rd and rd!=0, busy[rd] <= 1.
- Simultaneous set and clear of the same busy bit (a writeback clears rd while an accepted instruction sets it): set wins.
- Drain: out_valid & out_ready & no accept -> out_valid <= 0.
- Back-pressure: while out_valid & !out_ready, all out_* hold stable.
- flush:
  - Next cycle out_valid=0 and all busy bits are cleared.
  - No accept occurs in the flush cycle.
  - A writeback in the flush cycle still updates the array.
  - Contract: flush is asserted only when no older instruction has an outstanding writeback.
- in_params is ignored when in_valid=0.
- Reset mid-operation: the next cycle equals the reset state; any pending writeback in that cycle is discarded.

Decomposition:
- reg_file_pkg holds:
  - reg_file_read_params_t (existing);
  - a new reg_file_write_params_t {rd, data};
  - a new reg_file_operands_t {rs1_data, rs2_data, rd, writes_rd};
  - REGISTER_X0.
- Sub-module reg_file_scoreboard:
  - Holds the busy-bit vector with set, clear and flush.
  - Outputs busy lookups for rs1, rs2 and rd.
- The array, bypass and output register stay in the top.

Test Plan:
- After reset, issue rs1=x0, rs2=x0 -> next cycle out_valid=1, both operands 0, and regs read 0.
- Writeback x5=0xDEADBEEF; next cycle issue rs1=x5 -> out_rs1_data=0xDEADBEEF after 1 cycle.
- Issue rd=x7 with writes_rd=1, then issue rs2=x7 -> in_ready=0 until writeback x7=0x1234. In the writeback cycle the instruction is accepted via bypass, and out_rs2_data=0x1234.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0. Release -> the next instruction is accepted the same cycle.
- Writeback x0=0xFFFFFFFF, then read x0 -> 0. Issue rd=x0 with writes_rd=1, then read x0 -> no stall.
- Set busy[x3], then assert flush -> next cycle out_valid=0 and an instruction reading x3 is accepted without stall. Writeback x9=0x55 in the flush cycle -> regs[9]=0x55.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register-file read stage.
package reg_file_pkg;

  localparam int RF_XLEN     = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  localparam logic [RF_ADDR_W-1:0] REGISTER_X0 = '0;

  // Register fields produced by decode for one instruction.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
  } reg_file_read_params_t;

  // One writeback into the architectural array.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_XLEN-1:0]   data;
  } reg_file_write_params_t;

  // Operand bundle handed to execute.
  typedef struct packed {
    logic [RF_XLEN-1:0]   rs1_data;
    logic [RF_XLEN-1:0]   rs2_data;
    logic [RF_ADDR_W-1:0] rd;
    logic                 writes_rd;
  } reg_file_operands_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set when an
// instruction that writes it is issued, cleared by its writeback.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          flush,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic          busy_rs1,
  output logic          busy_rs2,
  output logic          busy_rd
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clear first so a same-cycle set of the same bit wins.
  always_comb begin
    // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (flush)  busy_d = '0;
    busy_d[REGISTER_X0] = 1'b0;
  end

  // Busy-bit state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_rs1 = busy_q[rs1];
  assign busy_rs2 = busy_q[rs2];
  assign busy_rd  = busy_q[rd];

endmodule

// File: rtl/reg_file_read_stage.sv
// Operand-fetch stage: owns the architectural registers, bypasses the
// current writeback into reads, stalls on RAW/WAW through the scoreboard and
// registers the operands for execute behind a valid/ready handshake.
// The struct types in reg_file_pkg are sized by the package constants, so
// XLEN/NUM_REGS must stay equal to RF_XLEN/RF_NUM_REGS.
module reg_file_read_stage
  import reg_file_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NUM_REGS = RF_NUM_REGS,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  reg_file_read_params_t in_params,
  input  logic                  in_writes_rd,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [AW-1:0]         out_rd,
  output logic                  out_writes_rd
);

  reg_file_write_params_t wb;
  logic                   wb_live;

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  logic               out_valid_q, out_valid_d;
  reg_file_operands_t out_q, out_d;

  logic            byp_rs1, byp_rs2, clr_rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            busy_rs1, busy_rs2, busy_rd;
  logic            hazard, accept, sets_busy;

  assign wb      = '{rd: wb_rd, data: wb_data};
  assign wb_live = wb_valid && (wb.rd != REGISTER_X0);

  // Array write port: x0 is never written, so it always reads zero.
  always_comb begin
    regs_d = regs_q;
    if (wb_live) regs_d[wb.rd] = wb.data;
  end

  // Architectural register array.
  always_ff @(posedge clk) begin
    // NOTE: the array is reset because the architectural state must come up all-zero; this keeps it in flops, not RAM.
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read ports with same-cycle writeback bypass.
  always_comb begin
    byp_rs1 = wb_live && (wb.rd == in_params.rs1);
    byp_rs2 = wb_live && (wb.rd == in_params.rs2);
    clr_rd  = wb_live && (wb.rd == in_params.rd);
    rs1_val = (in_params.rs1 == REGISTER_X0) ? '0 : byp_rs1 ? wb.data : regs_q[in_params.rs1];
    rs2_val = (in_params.rs2 == REGISTER_X0) ? '0 : byp_rs2 ? wb.data : regs_q[in_params.rs2];
  end

  // Hazard detection and input handshake.
  always_comb begin
    sets_busy = in_writes_rd && (in_params.rd != REGISTER_X0);
    hazard    = (busy_rs1 && !byp_rs1) ||
                (busy_rs2 && !byp_rs2) ||
                (sets_busy && busy_rd && !clr_rd);
    in_ready  = (!out_valid_q || out_ready) && !hazard && !flush;
    accept    = in_valid && in_ready;
  end

  reg_file_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && sets_busy),
    .set_idx  (in_params.rd),
    .clr_en   (wb_live),
    .clr_idx  (wb.rd),
    .flush    (flush),
    .rs1      (in_params.rs1),
    .rs2      (in_params.rs2),
    .rd       (in_params.rd),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd)
  );

  // Output register next state: flush squashes, accept loads, handshake drains.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = '{rs1_data: rs1_val, rs2_data: rs2_val,
                      rd: in_params.rd, writes_rd: in_writes_rd};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register toward execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rs1_data  = out_q.rs1_data;
  assign out_rs2_data  = out_q.rs2_data;
  assign out_rd        = out_q.rd;
  assign out_writes_rd = out_q.writes_rd;

endmodule

// File: tb/tb_reg_file_read_stage.sv
// Self-checking bench for reg_file_read_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_reg_file_read_stage;
  import reg_file_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  reg_file_read_params_t in_params;
  logic                  in_writes_rd;
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [31:0]           wb_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_rs1_data;
  logic [31:0]           out_rs2_data;
  logic [4:0]            out_rd;
  logic                  out_writes_rd;

  always #5 clk = ~clk;

  reg_file_read_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_params     (in_params),
    .in_writes_rd  (in_writes_rd),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1_data  (out_rs1_data),
    .out_rs2_data  (out_rs2_data),
    .out_rd        (out_rd),
    .out_writes_rd (out_writes_rd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Behavioural model: architectural values, outstanding writers, output slot.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_rs1, m_rs2;
  logic [4:0]  m_rd;
  bit          m_wr;
  bit          seen_ready;

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_valid && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit waits_on(input logic [4:0] r);
    return m_busy[r] && !(wb_valid && wb_rd == r);
  endfunction

  // Drive one cycle of inputs, check the handshake mid-cycle, advance the
  // model at the edge and check the registered outputs just after it.
  task automatic cycle(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input bit wr, input bit wv,
                       input logic [4:0] wrd, input logic [31:0] wd,
                       input bit fl, input bit ordy, input bit rs = 1'b0);
    bit          exp_ready, acc;
    logic [31:0] v1, v2;
    rst = rs; in_valid = iv; in_params = '{rs1: r1, rs2: r2, rd: d};
    in_writes_rd = wr; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    flush = fl; out_ready = ordy;
    @(negedge clk);
    exp_ready = (!m_valid || ordy) && !fl && !waits_on(r1) && !waits_on(r2)
                && !(wr && d != 0 && waits_on(d));
    seen_ready = in_ready;
    if (iv && !rs) check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    acc = iv && exp_ready;
    v1  = model_read(r1);
    v2  = model_read(r2);
    @(posedge clk);
    if (rs) begin
      foreach (m_regs[i]) begin m_regs[i] = 0; m_busy[i] = 0; end
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wr = 0;
    end else begin
      if (wv && wrd != 0) begin m_regs[wrd] = wd; m_busy[wrd] = 0; end
      if (fl) begin
        foreach (m_busy[i]) m_busy[i] = 0;
        m_valid = 0;
      end else if (acc) begin
        m_valid = 1; m_rs1 = v1; m_rs2 = v2; m_rd = d; m_wr = wr;
        if (wr && d != 0) m_busy[d] = 1;
      end else if (ordy) begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_rs1_data", out_rs1_data, m_rs1);
    check("out_rs2_data", out_rs2_data, m_rs2);
    check("out_rd_wr", {26'b0, out_writes_rd, out_rd}, {26'b0, m_wr, m_rd});
  endtask

  task automatic idle(input bit ordy = 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    // Reset.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_rs1", out_rs1_data, 32'h0);

    // x0 operands straight after reset.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("x0_valid", {31'b0, out_valid}, 32'h1);
    check("x0_rs2", out_rs2_data, 32'h0);

    // Writeback then read.
    cycle(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 1);
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    check("x5_read", out_rs1_data, 32'hDEADBEEF);

    // RAW stall on x7 resolved by bypass.
    cycle(1, 0, 0, 7, 1, 0, 0, 0, 0, 1);
    cycle(1, 0, 7, 0, 0, 0, 0, 0, 0, 1);
    check("raw_stall", {31'b0, seen_ready}, 32'h0);
    cycle(1, 0, 7, 0, 0, 0, 0, 0, 0, 1);
    check("raw_stall2", {31'b0, seen_ready}, 32'h0);
    cycle(1, 0, 7, 0, 0, 1, 7, 32'h1234, 0, 1);
    check("raw_bypass_ready", {31'b0, seen_ready}, 32'h1);
    check("raw_bypass_data", out_rs2_data, 32'h1234);

    // Back-pressure for three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      check("bp_ready", {31'b0, seen_ready}, 32'h0);
      check("bp_hold", out_rs2_data, 32'h1234);
    end
    cycle(1, 0, 0, 3, 0, 0, 0, 0, 0, 1);
    check("bp_release_ready", {31'b0, seen_ready}, 32'h1);
    check("bp_release_rd", {27'b0, out_rd}, 32'd3);

    // x0 ignores writes and never becomes busy.
    cycle(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 1);
    cycle(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("x0_after_wb", out_rs1_data, 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("x0_no_stall", {31'b0, seen_ready}, 32'h1);

    // Flush clears busy bits; writeback in the flush cycle still lands.
    cycle(1, 0, 0, 3, 1, 0, 0, 0, 0, 1);
    cycle(1, 3, 0, 0, 0, 1, 9, 32'h55, 1, 0);
    check("flush_ready", {31'b0, seen_ready}, 32'h0);
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    cycle(1, 3, 3, 0, 0, 0, 0, 0, 0, 1);
    check("post_flush_ready", {31'b0, seen_ready}, 32'h1);
    cycle(1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
    check("flush_cycle_wb", out_rs1_data, 32'h55);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 199) == 0);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
